rename_rat_freelist: RTL and testbench

//  Rename-side consumer of commit's retirement outputs: speculative front-end RAT plus physical-register free list.
//  - Rename looks up source and destination mappings and allocates new physical destination registers.
//  - Commit returns freed physical registers and advances the retired allocation pointer.
//  - On flush, the RAT is reloaded from commit's packed retirement RAT, and the free-list head rolls back to the retired head.

---
 rtl/rename_rat_freelist_if.sv | 40 ++++
 rtl/rename_rat_freelist.sv | 98 +++++++++
 tb/tb_rename_rat_freelist.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_rat_freelist_if.sv
// Rename/commit bus for the RAT + free-list block: rename lookups and allocation,
// commit frees and retire pointer advance, and the flush restore from the retirement RAT.
interface rename_rat_freelist_if;
  // Rename side
  logic         tREN_allocReq_IN;
  logic [4:0]   tREN_archDest_IN;
  logic [4:0]   tREN_archSrc1_IN;
  logic [4:0]   tREN_archSrc2_IN;
  logic [5:0]   fREN_physSrc1_OUT;
  logic [5:0]   fREN_physSrc2_OUT;
  logic [5:0]   fREN_physDest_OUT;
  logic [5:0]   fREN_oldPhysDest_OUT;
  logic         fREN_allocAck_OUT;
  // Free-list status
  logic         fFL_empty_OUT;
  logic [5:0]   fFL_count_OUT;
  logic         fFL_overflow_OUT;
  // Commit side
  logic         tFL_freeReq_IN;
  logic [5:0]   tFL_freeId_IN;
  logic         tFL_commitAlloc_IN;
  logic         tRAT_copyRetRat_IN;
  logic [191:0] tRAT_retRat_IN;

  modport master (
    output tREN_allocReq_IN, tREN_archDest_IN, tREN_archSrc1_IN, tREN_archSrc2_IN,
    output tFL_freeReq_IN, tFL_freeId_IN, tFL_commitAlloc_IN,
    output tRAT_copyRetRat_IN, tRAT_retRat_IN,
    input  fREN_physSrc1_OUT, fREN_physSrc2_OUT, fREN_physDest_OUT, fREN_oldPhysDest_OUT,
    input  fREN_allocAck_OUT, fFL_empty_OUT, fFL_count_OUT, fFL_overflow_OUT
  );

  modport slave (
    input  tREN_allocReq_IN, tREN_archDest_IN, tREN_archSrc1_IN, tREN_archSrc2_IN,
    input  tFL_freeReq_IN, tFL_freeId_IN, tFL_commitAlloc_IN,
    input  tRAT_copyRetRat_IN, tRAT_retRat_IN,
    output fREN_physSrc1_OUT, fREN_physSrc2_OUT, fREN_physDest_OUT, fREN_oldPhysDest_OUT,
    output fREN_allocAck_OUT, fFL_empty_OUT, fFL_count_OUT, fFL_overflow_OUT
  );
endinterface

// File: rtl/rename_rat_freelist.sv
// Speculative front-end RAT plus circular physical-register free list with a
// retired head pointer so a flush can roll allocation back to the committed point.
module rename_rat_freelist (
  input logic                  CLK,
  input logic                  RESET,
  input logic                  FREEZE,
  rename_rat_freelist_if.slave bus
);

  // Handshake: rename holds allocReq (with archDest) until allocAck is seen high in
  // the same cycle; on that cycle physDest is the granted id, consumed at the posedge.

  logic [5:0] rat_q [32];
  logic [5:0] rat_d [32];
  logic [5:0] fl_q  [32];
  logic [5:0] fl_d  [32];
  logic [5:0] head_q, head_d;
  logic [5:0] ret_head_q, ret_head_d;
  logic [5:0] tail_q, tail_d;
  logic       overflow_q, overflow_d;

  logic [5:0] count;
  logic       empty;
  logic       full;
  logic       alloc_ack;

  always_comb begin
    count     = tail_q - head_q;
    empty     = (count == 6'd0);
    full      = (count == 6'd32);
    alloc_ack = bus.tREN_allocReq_IN && !empty && (bus.tREN_archDest_IN != 5'd0) &&
                !FREEZE && !bus.tRAT_copyRetRat_IN;
  end

  // Lookups see only current state; a same-cycle allocation is not bypassed.
  assign bus.fREN_physSrc1_OUT    = rat_q[bus.tREN_archSrc1_IN];
  assign bus.fREN_physSrc2_OUT    = rat_q[bus.tREN_archSrc2_IN];
  assign bus.fREN_oldPhysDest_OUT = rat_q[bus.tREN_archDest_IN];
  assign bus.fREN_physDest_OUT    = fl_q[head_q[4:0]];
  assign bus.fREN_allocAck_OUT    = alloc_ack;
  assign bus.fFL_empty_OUT        = empty;
  assign bus.fFL_count_OUT        = count;
  assign bus.fFL_overflow_OUT     = overflow_q;

  always_comb begin
    rat_d      = rat_q;
    fl_d       = fl_q;
    head_d     = head_q;
    ret_head_d = ret_head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    if (!FREEZE) begin
      if (alloc_ack) begin
        rat_d[bus.tREN_archDest_IN] = fl_q[head_q[4:0]];
        head_d = head_q + 6'd1;
      end
      if (bus.tFL_freeReq_IN) begin
        if (!full) begin
          fl_d[tail_q[4:0]] = bus.tFL_freeId_IN;
          tail_d = tail_q + 6'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      if (bus.tFL_commitAlloc_IN) begin
        ret_head_d = ret_head_q + 6'd1;
      end
      // Flush rolls head back to the retired point including this cycle's commit.
      if (bus.tRAT_copyRetRat_IN) begin
        for (int i = 0; i < 32; i++) begin
          rat_d[i] = bus.tRAT_retRat_IN[191 - 6*i -: 6];
        end
        head_d = ret_head_d;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) begin
        rat_q[i] <= 6'(i);
        fl_q[i]  <= 6'(i + 32);
      end
      head_q     <= 6'd0;
      ret_head_q <= 6'd0;
      tail_q     <= 6'b100000;
      overflow_q <= 1'b0;
    end else begin
      rat_q      <= rat_d;
      fl_q       <= fl_d;
      head_q     <= head_d;
      ret_head_q <= ret_head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_rename_rat_freelist.sv
// Bench for rename_rat_freelist: directed scenarios plus a randomized run checked
// against a log-based model (every pushed id kept in order, absolute alloc/retire counts).
module tb_rename_rat_freelist;

  logic CLK = 1'b0;
  logic RESET;
  logic FREEZE;

  rename_rat_freelist_if bus();

  rename_rat_freelist dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .FREEZE (FREEZE),
    .bus    (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: m_ids holds every id ever pushed, in order; the head is
  // m_alloc (count of allocations), the retired head is m_ret.
  int m_rat [32];
  int m_ids [$];
  int m_alloc;
  int m_ret;
  bit m_ovf;

  function automatic int m_count();
    return m_ids.size() - m_alloc;
  endfunction

  task automatic model_reset();
    m_ids.delete();
    for (int i = 0; i < 32; i++) begin
      m_rat[i] = i;
      m_ids.push_back(32 + i);
    end
    m_alloc = 0;
    m_ret   = 0;
    m_ovf   = 1'b0;
  endtask

  function automatic bit m_ack();
    return bus.tREN_allocReq_IN && (m_count() > 0) && (bus.tREN_archDest_IN != 0) &&
           !FREEZE && !bus.tRAT_copyRetRat_IN;
  endfunction

  // Applies one clock's worth of the rules to the model using the currently driven inputs.
  task automatic model_step();
    bit ack;
    int cnt;
    if (FREEZE) return;
    ack = m_ack();
    cnt = m_count();
    if (ack) begin
      m_rat[bus.tREN_archDest_IN] = m_ids[m_alloc];
      m_alloc++;
    end
    if (bus.tFL_freeReq_IN) begin
      if (cnt < 32) m_ids.push_back(int'(bus.tFL_freeId_IN));
      else m_ovf = 1'b1;
    end
    if (bus.tFL_commitAlloc_IN) m_ret++;
    if (bus.tRAT_copyRetRat_IN) begin
      for (int i = 0; i < 32; i++) m_rat[i] = int'(bus.tRAT_retRat_IN[191 - 6*i -: 6]);
      m_alloc = m_ret;
    end
  endtask

  // Drives one cycle's inputs at the negedge and settles for sampling.
  task automatic drive(input bit a, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input bit f, input logic [5:0] fid,
                       input bit c, input bit cp, input logic [191:0] rr, input bit fz);
    @(negedge CLK);
    bus.tREN_allocReq_IN   = a;
    bus.tREN_archDest_IN   = d;
    bus.tREN_archSrc1_IN   = s1;
    bus.tREN_archSrc2_IN   = s2;
    bus.tFL_freeReq_IN     = f;
    bus.tFL_freeId_IN      = fid;
    bus.tFL_commitAlloc_IN = c;
    bus.tRAT_copyRetRat_IN = cp;
    bus.tRAT_retRat_IN     = rr;
    FREEZE                 = fz;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    bus.tREN_allocReq_IN = 0; bus.tFL_freeReq_IN = 0; bus.tFL_commitAlloc_IN = 0;
    bus.tRAT_copyRetRat_IN = 0; FREEZE = 0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();
  endtask

  function automatic logic [191:0] identity_ret();
    logic [191:0] rr;
    for (int i = 0; i < 32; i++) rr[191 - 6*i -: 6] = 6'(i);
    return rr;
  endfunction

  task automatic test_reset();
    do_reset();
    drive(0, 0, 5, 0, 0, 0, 0, 0, '0, 0);
    n_cmp++; if (bus.fFL_count_OUT !== 6'd32) begin n_bad++; $display("FAIL reset_count got %0d want 32", bus.fFL_count_OUT); end
    n_cmp++; if (bus.fFL_empty_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_empty got %0b want 0", bus.fFL_empty_OUT); end
    n_cmp++; if (bus.fREN_physSrc1_OUT !== 6'd5) begin n_bad++; $display("FAIL reset_src1 got %0d want 5", bus.fREN_physSrc1_OUT); end
    n_cmp++; if (bus.fREN_physDest_OUT !== 6'd32) begin n_bad++; $display("FAIL reset_dest got %0d want 32", bus.fREN_physDest_OUT); end
    n_cmp++; if (bus.fFL_overflow_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %0b want 0", bus.fFL_overflow_OUT); end
    model_step();
  endtask

  task automatic test_alloc_seq();
    int dests [3] = '{3, 4, 3};
    int ids [3]   = '{32, 33, 34};
    int olds [3]  = '{3, 4, 32};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(dests[i]), 0, 0, 0, 0, 0, 0, '0, 0);
      n_cmp++; if (bus.fREN_allocAck_OUT !== 1'b1) begin n_bad++; $display("FAIL alloc_ack[%0d] got %0b want 1", i, bus.fREN_allocAck_OUT); end
      n_cmp++; if (bus.fREN_physDest_OUT !== 6'(ids[i])) begin n_bad++; $display("FAIL alloc_dest[%0d] got %0d want %0d", i, bus.fREN_physDest_OUT, ids[i]); end
      n_cmp++; if (bus.fREN_oldPhysDest_OUT !== 6'(olds[i])) begin n_bad++; $display("FAIL alloc_old[%0d] got %0d want %0d", i, bus.fREN_oldPhysDest_OUT, olds[i]); end
      model_step();
    end
    drive(0, 0, 3, 4, 0, 0, 0, 0, '0, 0);
    n_cmp++; if (bus.fREN_physSrc1_OUT !== 6'd34) begin n_bad++; $display("FAIL alloc_rat3 got %0d want 34", bus.fREN_physSrc1_OUT); end
    n_cmp++; if (bus.fREN_physSrc2_OUT !== 6'd33) begin n_bad++; $display("FAIL alloc_rat4 got %0d want 33", bus.fREN_physSrc2_OUT); end
    n_cmp++; if (bus.fFL_count_OUT !== 6'd29) begin n_bad++; $display("FAIL alloc_count got %0d want 29", bus.fFL_count_OUT); end
    model_step();
  endtask

  task automatic test_empty();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1, 5'(i % 31 + 1), 0, 0, 0, 0, 0, 0, '0, 0);
      model_step();
    end
    drive(1, 5'd1, 0, 0, 0, 0, 0, 0, '0, 0);
    n_cmp++; if (bus.fFL_empty_OUT !== 1'b1) begin n_bad++; $display("FAIL empty_flag got %0b want 1", bus.fFL_empty_OUT); end
    n_cmp++; if (bus.fFL_count_OUT !== 6'd0) begin n_bad++; $display("FAIL empty_count got %0d want 0", bus.fFL_count_OUT); end
    n_cmp++; if (bus.fREN_allocAck_OUT !== 1'b0) begin n_bad++; $display("FAIL empty_ack got %0b want 0", bus.fREN_allocAck_OUT); end
    model_step();
    drive(1, 5'd1, 0, 0, 1, 6'd7, 0, 0, '0, 0);
    n_cmp++; if (bus.fREN_allocAck_OUT !== 1'b0) begin n_bad++; $display("FAIL empty_nobypass got %0b want 0", bus.fREN_allocAck_OUT); end
    model_step();
    drive(1, 5'd2, 0, 0, 0, 0, 0, 0, '0, 0);
    n_cmp++; if (bus.fREN_allocAck_OUT !== 1'b1) begin n_bad++; $display("FAIL refill_ack got %0b want 1", bus.fREN_allocAck_OUT); end
    n_cmp++; if (bus.fREN_physDest_OUT !== 6'd7) begin n_bad++; $display("FAIL refill_dest got %0d want 7", bus.fREN_physDest_OUT); end
    model_step();
  endtask

  task automatic test_flush();
    logic [191:0] rr;
    rr = identity_ret();
    rr[191 - 6*3 -: 6] = 6'd32;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(3 + i), 0, 0, 0, 0, 0, 0, '0, 0);
      model_step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, '0, 0);
    model_step();
    drive(1, 5'd6, 0, 0, 0, 0, 0, 1, rr, 0);
    n_cmp++; if (bus.fREN_allocAck_OUT !== 1'b0) begin n_bad++; $display("FAIL flush_ack got %0b want 0", bus.fREN_allocAck_OUT); end
    model_step();
    drive(0, 5'd5, 3, 4, 0, 0, 0, 0, '0, 0);
    n_cmp++; if (bus.fREN_physSrc1_OUT !== 6'd32) begin n_bad++; $display("FAIL flush_rat3 got %0d want 32", bus.fREN_physSrc1_OUT); end
    n_cmp++; if (bus.fREN_physSrc2_OUT !== 6'd4) begin n_bad++; $display("FAIL flush_rat4 got %0d want 4", bus.fREN_physSrc2_OUT); end
    n_cmp++; if (bus.fREN_oldPhysDest_OUT !== 6'd5) begin n_bad++; $display("FAIL flush_rat5 got %0d want 5", bus.fREN_oldPhysDest_OUT); end
    n_cmp++; if (bus.fFL_count_OUT !== 6'd31) begin n_bad++; $display("FAIL flush_count got %0d want 31", bus.fFL_count_OUT); end
    n_cmp++; if (bus.fREN_physDest_OUT !== 6'd33) begin n_bad++; $display("FAIL flush_head got %0d want 33", bus.fREN_physDest_OUT); end
    model_step();
  endtask

  task automatic test_overflow();
    do_reset();
    drive(0, 0, 0, 0, 1, 6'd9, 0, 0, '0, 0);
    n_cmp++; if (bus.fFL_overflow_OUT !== 1'b0) begin n_bad++; $display("FAIL ovf_pre got %0b want 0", bus.fFL_overflow_OUT); end
    model_step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    n_cmp++; if (bus.fFL_overflow_OUT !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %0b want 1", bus.fFL_overflow_OUT); end
    n_cmp++; if (bus.fFL_count_OUT !== 6'd32) begin n_bad++; $display("FAIL ovf_count got %0d want 32", bus.fFL_count_OUT); end
    model_step();
    repeat (3) begin idle(); model_step(); end
    n_cmp++; if (bus.fFL_overflow_OUT !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0b want 1", bus.fFL_overflow_OUT); end
    do_reset();
    idle();
    n_cmp++; if (bus.fFL_overflow_OUT !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %0b want 0", bus.fFL_overflow_OUT); end
    model_step();
  endtask

  task automatic test_freeze();
    logic [191:0] rr;
    for (int i = 0; i < 32; i++) rr[191 - 6*i -: 6] = (i == 0) ? 6'd0 : 6'd1;
    do_reset();
    drive(1, 5'd3, 0, 0, 1, 6'd9, 1, 1, rr, 1);
    n_cmp++; if (bus.fREN_allocAck_OUT !== 1'b0) begin n_bad++; $display("FAIL frz_ack got %0b want 0", bus.fREN_allocAck_OUT); end
    model_step();
    drive(1, 5'd3, 3, 7, 0, 0, 0, 0, '0, 0);
    n_cmp++; if (bus.fFL_count_OUT !== 6'd32) begin n_bad++; $display("FAIL frz_count got %0d want 32", bus.fFL_count_OUT); end
    n_cmp++; if (bus.fFL_overflow_OUT !== 1'b0) begin n_bad++; $display("FAIL frz_ovf got %0b want 0", bus.fFL_overflow_OUT); end
    n_cmp++; if (bus.fREN_physSrc2_OUT !== 6'd7) begin n_bad++; $display("FAIL frz_rat7 got %0d want 7", bus.fREN_physSrc2_OUT); end
    n_cmp++; if (bus.fREN_allocAck_OUT !== 1'b1) begin n_bad++; $display("FAIL frz_resume_ack got %0b want 1", bus.fREN_allocAck_OUT); end
    n_cmp++; if (bus.fREN_physDest_OUT !== 6'd32) begin n_bad++; $display("FAIL frz_resume_dest got %0d want 32", bus.fREN_physDest_OUT); end
    model_step();
    drive(0, 0, 3, 0, 0, 0, 0, 0, '0, 0);
    n_cmp++; if (bus.fREN_physSrc1_OUT !== 6'd32) begin n_bad++; $display("FAIL frz_after_rat3 got %0d want 32", bus.fREN_physSrc1_OUT); end
    model_step();
  endtask

  task automatic test_random();
    bit a, f, c, cp, fz;
    logic [191:0] rr;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(0, 3) != 0);
      fz = ($urandom_range(0, 9) == 0);
      cp = ($urandom_range(0, 24) == 0);
      c  = (m_ret < m_alloc) && ($urandom_range(0, 2) == 0);
      // Keep retained entries intact: never push into a slot the retired head still owns.
      f  = (m_ids.size() - m_ret < 32) && ($urandom_range(0, 1) == 1);
      rr = '0;
      for (int i = 1; i < 32; i++) rr[191 - 6*i -: 6] = 6'($urandom_range(0, 63));
      drive(a, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            f, 6'($urandom_range(0, 63)), c, cp, rr, fz);
      n_cmp++; if (bus.fREN_allocAck_OUT !== m_ack()) begin n_bad++; $display("FAIL rnd_ack[%0d] got %0b want %0b", n, bus.fREN_allocAck_OUT, m_ack()); end
      n_cmp++; if (bus.fFL_count_OUT !== 6'(m_count())) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, bus.fFL_count_OUT, m_count()); end
      n_cmp++; if (bus.fFL_empty_OUT !== (m_count() == 0)) begin n_bad++; $display("FAIL rnd_empty[%0d] got %0b want %0b", n, bus.fFL_empty_OUT, m_count() == 0); end
      n_cmp++; if (bus.fFL_overflow_OUT !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf[%0d] got %0b want %0b", n, bus.fFL_overflow_OUT, m_ovf); end
      n_cmp++; if (bus.fREN_physSrc1_OUT !== 6'(m_rat[bus.tREN_archSrc1_IN])) begin n_bad++; $display("FAIL rnd_src1[%0d] got %0d want %0d", n, bus.fREN_physSrc1_OUT, m_rat[bus.tREN_archSrc1_IN]); end
      n_cmp++; if (bus.fREN_physSrc2_OUT !== 6'(m_rat[bus.tREN_archSrc2_IN])) begin n_bad++; $display("FAIL rnd_src2[%0d] got %0d want %0d", n, bus.fREN_physSrc2_OUT, m_rat[bus.tREN_archSrc2_IN]); end
      n_cmp++; if (bus.fREN_oldPhysDest_OUT !== 6'(m_rat[bus.tREN_archDest_IN])) begin n_bad++; $display("FAIL rnd_old[%0d] got %0d want %0d", n, bus.fREN_oldPhysDest_OUT, m_rat[bus.tREN_archDest_IN]); end
      if (m_count() > 0) begin
        n_cmp++; if (bus.fREN_physDest_OUT !== 6'(m_ids[m_alloc])) begin n_bad++; $display("FAIL rnd_dest[%0d] got %0d want %0d", n, bus.fREN_physDest_OUT, m_ids[m_alloc]); end
      end
      model_step();
    end
  endtask

  initial begin
    RESET  = 1'b0;
    FREEZE = 1'b0;
    bus.tREN_allocReq_IN = 0; bus.tREN_archDest_IN = 0; bus.tREN_archSrc1_IN = 0;
    bus.tREN_archSrc2_IN = 0; bus.tFL_freeReq_IN = 0; bus.tFL_freeId_IN = 0;
    bus.tFL_commitAlloc_IN = 0; bus.tRAT_copyRetRat_IN = 0; bus.tRAT_retRat_IN = '0;
    test_reset();
    test_alloc_seq();
    test_empty();
    test_flush();
    test_overflow();
    test_freeze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
